alu_entry_sequencer: RTL and testbench

//  Front-end controller for the board ALU. Debounces the three pushbuttons (A, B, OP), enforces the

---
 rtl/alu_entry_sequencer_pkg.sv | 23 ++
 rtl/alu_entry_sequencer_if.sv | 31 +++
 rtl/alu_entry_sequencer_debounce.sv | 41 ++++
 rtl/alu_entry_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_entry_sequencer.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/alu_entry_sequencer_pkg.sv
// Shared definitions for the ALU entry sequencer: FSM state codes and parameter defaults.
package alu_seq_pkg;
  localparam int DW_DEF             = 8;
  localparam int OPW_DEF            = 4;
  localparam int DB_CYCLES_DEF      = 20;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GOT_A = 3'd1;
  localparam logic [2:0] ST_GOT_B = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_SHOW  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_GOT_A = ST_GOT_A,
    S_GOT_B = ST_GOT_B,
    S_EXEC  = ST_EXEC,
    S_WAIT  = ST_WAIT,
    S_SHOW  = ST_SHOW
  } seq_state_e;
endpackage

// File: rtl/alu_entry_sequencer_if.sv
// Board-I/O / ALU bundle for the entry sequencer; slave = sequencer, master = board side.
interface alu_entry_sequencer_if
  import alu_seq_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int OPW = OPW_DEF
);
  logic           pb_a;
  logic           pb_b;
  logic           pb_op;
  logic [DW-1:0]  sw;
  logic           alu_valid;
  logic [DW-1:0]  alu_result;
  logic [DW-1:0]  a_out;
  logic [DW-1:0]  b_out;
  logic [OPW-1:0] op_out;
  logic           alu_go;
  logic [DW-1:0]  result_out;
  logic [2:0]     state_out;
  logic           err;

  modport master (
    output pb_a, pb_b, pb_op, sw, alu_valid, alu_result,
    input  a_out, b_out, op_out, alu_go, result_out, state_out, err
  );

  modport slave (
    input  pb_a, pb_b, pb_op, sw, alu_valid, alu_result,
    output a_out, b_out, op_out, alu_go, result_out, state_out, err
  );
endinterface

// File: rtl/alu_entry_sequencer_debounce.sv
// pb_debounce: 2-FF synchroniser, stability counter and one-cycle press pulse on a debounced rise.
module pb_debounce #(
  parameter int DB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_press
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          r_sync1, r_sync2, r_level, r_press;
  logic [CW-1:0] r_cnt;

  // Counter runs only while the synchronised level differs from the accepted one,
  // so any return to the accepted level (bounce) restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;
endmodule

// File: rtl/alu_entry_sequencer.sv
// Enforces A -> B -> OP entry from debounced buttons, strobes the ALU and holds its result.
// Optional WAIT timeout is built when ALU_SEQ_TIMEOUT_EN is defined.
module alu_entry_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int OPW       = OPW_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
`ifdef ALU_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic                  Clk,
  input  logic                  reset,
  alu_entry_sequencer_if.slave  bus
);
  logic [2:0] w_raw, w_press;
  logic       w_pa, w_pb, w_po;

  assign w_raw = {bus.pb_op, bus.pb_b, bus.pb_a};

  pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db [2:0] (
    .clk     (Clk),
    .rst_n   (reset),
    .i_raw   (w_raw),
    .o_press (w_press)
  );

  // Same-cycle priority A > B > OP.
  assign w_pa = w_press[0];
  assign w_pb = w_press[1] & ~w_press[0];
  assign w_po = w_press[2] & ~w_press[1] & ~w_press[0];

  seq_state_e     r_state;
  logic [DW-1:0]  r_a, r_b, r_res;
  logic [OPW-1:0] r_op;
  logic           r_go;
`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to;
  logic          r_err;
`endif

  always_ff @(posedge Clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_res   <= '0;
      r_go    <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      r_to    <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_go <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      if ((w_pa && r_state inside {S_IDLE, S_GOT_A, S_GOT_B, S_SHOW}) ||
          (w_po && r_state inside {S_GOT_B, S_SHOW}))
        r_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: if (w_pa) begin
          r_a     <= bus.sw;
          r_state <= S_GOT_A;
        end
        S_GOT_A: begin
          if (w_pa) r_a <= bus.sw;
          else if (w_pb) begin
            r_b     <= bus.sw;
            r_state <= S_GOT_B;
          end
        end
        S_GOT_B: begin
          if (w_pa) begin
            r_a     <= bus.sw;
            r_state <= S_GOT_A;
          end else if (w_pb) begin
            r_b <= bus.sw;
          end else if (w_po) begin
            r_op    <= bus.sw[OPW-1:0];
            r_go    <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_state <= S_WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
          r_to    <= '0;
`endif
        end
        S_WAIT: begin
          if (bus.alu_valid) begin
            r_res   <= bus.alu_result;
            r_state <= S_SHOW;
          end
`ifdef ALU_SEQ_TIMEOUT_EN
          else if (r_to == TW'(TIMEOUT_CYCLES - 1)) begin
            r_res   <= '0;
            r_err   <= 1'b1;
            r_state <= S_SHOW;
          end else begin
            r_to <= r_to + 1'b1;
          end
`endif
        end
        S_SHOW: begin
          if (w_pa) begin
            r_a     <= bus.sw;
            r_state <= S_GOT_A;
          end else if (w_po) begin
            r_op    <= bus.sw[OPW-1:0];
            r_go    <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.a_out      = r_a;
  assign bus.b_out      = r_b;
  assign bus.op_out     = r_op;
  assign bus.alu_go     = r_go;
  assign bus.result_out = r_res;
  assign bus.state_out  = r_state;
`ifdef ALU_SEQ_TIMEOUT_EN
  assign bus.err        = r_err;
`else
  assign bus.err        = 1'b0;
`endif
endmodule

// File: tb/tb_alu_entry_sequencer.sv
// Directed bench for alu_entry_sequencer: reset, debounce, entry order, ALU handshake, abort, timeout.
module tb_alu_entry_sequencer;
  logic Clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   go_cnt = 0;
  int   g0, n;

  always #5 Clk = ~Clk;

  alu_entry_sequencer_if #(.DW(8), .OPW(4)) bus ();

  alu_entry_sequencer u_dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always @(posedge Clk) if (bus.alu_go === 1'b1) go_cnt <= go_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input int btn, input logic v);
    case (btn)
      0: bus.pb_a = v;
      1: bus.pb_b = v;
      default: bus.pb_op = v;
    endcase
  endtask

  // Clean push: held well beyond the debounce window, then released.
  task automatic push(input int btn, input logic [7:0] v);
    bus.sw = v;
    set_btn(btn, 1'b1);
    repeat (30) @(negedge Clk);
    set_btn(btn, 1'b0);
    repeat (30) @(negedge Clk);
  endtask

  initial begin
    // 1: reset with everything active
    reset = 1'b0;
    bus.pb_a = 1'b1; bus.pb_b = 1'b1; bus.pb_op = 1'b1;
    bus.sw = 8'hAA; bus.alu_valid = 1'b1; bus.alu_result = 8'h55;
    repeat (5) @(negedge Clk);
    chk("rst_state", bus.state_out, 0);
    chk("rst_a", bus.a_out, 0);
    chk("rst_b", bus.b_out, 0);
    chk("rst_op", bus.op_out, 0);
    chk("rst_res", bus.result_out, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_go_cnt", go_cnt, 0);
    bus.pb_a = 1'b0; bus.pb_b = 1'b0; bus.pb_op = 1'b0;
    @(negedge Clk);
    reset = 1'b1;
    repeat (5) @(negedge Clk);

    // 2: bouncing A then a long hold
    bus.sw = 8'h0F;
    for (int i = 0; i < 15; i++) begin
      bus.pb_a = 1'b1; #20;
      bus.pb_a = 1'b0; #20;
    end
    repeat (4) @(negedge Clk);
    chk("bounce_state", bus.state_out, 0);
    chk("bounce_a", bus.a_out, 0);
    bus.pb_a = 1'b1; #550;
    chk("hold_state", bus.state_out, 1);
    chk("hold_a", bus.a_out, 8'h0F);
    bus.sw = 8'h33; #200;
    chk("one_press_a", bus.a_out, 8'h0F);
    bus.pb_a = 1'b0;
    repeat (30) @(negedge Clk);

    // 3: full sequence, exact alu_go timing
    push(1, 8'h05);
    chk("seq_b", bus.b_out, 8'h05);
    chk("seq_state_b", bus.state_out, 2);
    bus.alu_valid = 1'b1; bus.alu_result = 8'h14;
    g0 = go_cnt;
    bus.sw = 8'h01;
    bus.pb_op = 1'b1;
    n = 0;
    while (bus.alu_go !== 1'b1 && n < 100) begin @(negedge Clk); n++; end
    chk("go_latency", n, 23);
    chk("go_state_exec", bus.state_out, 3);
    chk("seq_op", bus.op_out, 4'h1);
    @(negedge Clk);
    chk("go_one_cycle", bus.alu_go, 0);
    chk("wait_state", bus.state_out, 4);
    chk("wait_res_hold", bus.result_out, 0);
    @(negedge Clk);
    chk("show_state", bus.state_out, 5);
    chk("show_res", bus.result_out, 8'h14);
    bus.pb_op = 1'b0;
    repeat (30) @(negedge Clk);
    chk("seq_go_cnt", go_cnt - g0, 1);
    chk("seq_a_kept", bus.a_out, 8'h0F);

    // 4: out-of-order presses
    reset = 1'b0; repeat (2) @(negedge Clk); reset = 1'b1;
    g0 = go_cnt;
    push(2, 8'h07);
    push(1, 8'h06);
    chk("ooo_state", bus.state_out, 0);
    chk("ooo_op", bus.op_out, 0);
    chk("ooo_b", bus.b_out, 0);
    push(0, 8'h22);
    chk("ooo_state_a", bus.state_out, 1);
    push(2, 8'h07);
    chk("ooo_state_op", bus.state_out, 1);
    chk("ooo_op2", bus.op_out, 0);
    chk("ooo_go_cnt", go_cnt - g0, 0);

    // 5: reset while waiting for the ALU
    push(1, 8'h03);
    chk("ab_state", bus.state_out, 2);
    bus.alu_valid = 1'b0;
    push(2, 8'h09);
    chk("stall_state", bus.state_out, 4);
    chk("stall_op", bus.op_out, 4'h9);
    chk("stall_go_cnt", go_cnt - g0, 1);
    reset = 1'b0;
    @(negedge Clk);
    chk("abort_state", bus.state_out, 0);
    chk("abort_a", bus.a_out, 0);
    chk("abort_b", bus.b_out, 0);
    chk("abort_op", bus.op_out, 0);
    chk("abort_go", bus.alu_go, 0);
    reset = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_result = 8'h77;
    repeat (10) @(negedge Clk);
    chk("abort_res", bus.result_out, 0);
    chk("abort_state2", bus.state_out, 0);

`ifdef ALU_SEQ_TIMEOUT_EN
    // 6: WAIT timeout
    push(0, 8'h10);
    push(1, 8'h20);
    bus.alu_valid = 1'b0;
    bus.sw = 8'h02;
    bus.pb_op = 1'b1;
    n = 0;
    while (bus.state_out !== 3'd4 && n < 100) begin @(negedge Clk); n++; end
    chk("to_enter_wait", bus.state_out, 4);
    n = 0;
    while (bus.err !== 1'b1 && n < 400) begin @(negedge Clk); n++; end
    chk("to_latency", n, 255);
    chk("to_res", bus.result_out, 0);
    chk("to_state", bus.state_out, 5);
    bus.pb_op = 1'b0;
    repeat (30) @(negedge Clk);
    push(0, 8'h44);
    chk("to_err_clr", bus.err, 0);
    chk("to_state_a", bus.state_out, 1);
    chk("to_a", bus.a_out, 8'h44);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
